// File: rtl/miner_work_scheduler.sv
// Work scheduler for the blake miner core array: nonce-space slicing on new
// work, completion tracking, and round-robin merging of golden-nonce reports.
module miner_work_scheduler #(
   parameter int NUM_CORES = 4,
   parameter int CORE_BITS = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx_done,
   output logic [NUM_CORES-1:0]      core_load,
   output logic [31:0]               core_start_nonce,
   input  logic [NUM_CORES-1:0]      core_done,
   input  logic [NUM_CORES-1:0]      core_golden_valid,
   input  logic [32*NUM_CORES-1:0]   core_golden_nonce,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [31:0]               tx_nonce,
   output logic [CORE_BITS-1:0]      tx_core,
   output logic                      work_exhausted,
   output logic                      busy,
   output logic [7:0]                drop_count
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, EXHAUSTED} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CORE_BITS-1:0] load_idx;
   logic                 load_last;
   logic [NUM_CORES-1:0] done;

   logic [NUM_CORES-1:0] hold_valid;
   logic [31:0]          hold_nonce [NUM_CORES];
   logic [CORE_BITS-1:0] rr_ptr;
   logic [CORE_BITS-1:0] scan_idx;
   logic [CORE_BITS-1:0] gnt_idx;
   logic                 gnt_hit;
   logic                 loadable;
   logic                 gnt_fire;
   logic                 capture_en;
   logic [NUM_CORES-1:0] drain;
   logic [NUM_CORES-1:0] drop;
   logic [4:0]           drop_num;
   logic [8:0]           drop_sum;

   assign load_last = (load_idx == CORE_BITS'(NUM_CORES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (rx_done) begin
         state_nxt = LOAD;
      end else begin
         unique case (state)
            LOAD:    if (load_last) state_nxt = RUN;
            RUN:     if (&(done | core_done)) state_nxt = EXHAUSTED;
            default: ;
         endcase
      end
   end

   always_comb begin
      core_load        = '0;
      core_start_nonce = '0;
      busy             = 1'b0;
      work_exhausted   = 1'b0;
      unique case (state)
         LOAD: begin
            core_load        = NUM_CORES'(1) << load_idx;
            core_start_nonce = {load_idx, {(32-CORE_BITS){1'b0}}};
            busy             = 1'b1;
         end
         RUN:       busy = 1'b1;
         EXHAUSTED: work_exhausted = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_idx <= '0;
         done     <= '0;
      end else if (rx_done) begin
         load_idx <= '0;
         done     <= '0;
      end else begin
         if (state == LOAD) begin
            load_idx <= load_last ? '0 : load_idx + CORE_BITS'(1);
         end
         if (state == RUN) begin
            done <= done | core_done;
         end
      end
   end

   // Round-robin search starting at the pointer, wrapping over all cores
   always_comb begin
      gnt_hit  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         scan_idx = CORE_BITS'((int'(rr_ptr) + j) % NUM_CORES);
         if (!gnt_hit && hold_valid[scan_idx]) begin
            gnt_hit = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   // New work flushes holding registers, so nothing is granted that cycle
   assign loadable   = !tx_valid || tx_ready;
   assign gnt_fire   = loadable && gnt_hit && !rx_done;
   assign capture_en = (state != IDLE) && !rx_done;

   always_comb begin
      drain    = '0;
      drop     = '0;
      drop_num = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         drain[i] = gnt_fire && (gnt_idx == CORE_BITS'(i));
         drop[i]  = capture_en && core_golden_valid[i]
                    && hold_valid[i] && !drain[i];
         drop_num = drop_num + 5'(drop[i]);
      end
      drop_sum = 9'(drop_count) + 9'(drop_num);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_valid <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            hold_nonce[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (rx_done) begin
               hold_valid[i] <= 1'b0;
            end else if (capture_en && core_golden_valid[i]
                         && (!hold_valid[i] || drain[i])) begin
               hold_valid[i] <= 1'b1;
               hold_nonce[i] <= core_golden_nonce[32*i +: 32];
            end else if (drain[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_valid <= 1'b0;
         tx_nonce <= '0;
         tx_core  <= '0;
         rr_ptr   <= '0;
      end else if (loadable) begin
         tx_valid <= gnt_fire;
         if (gnt_fire) begin
            tx_nonce <= hold_nonce[gnt_idx];
            tx_core  <= gnt_idx;
            rr_ptr   <= (gnt_idx == CORE_BITS'(NUM_CORES - 1))
                        ? '0 : gnt_idx + CORE_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
      end else if (drop_num != '0) begin
         drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule

// File: tb/tb_miner_work_scheduler.sv
// Scoreboard bench for miner_work_scheduler: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_miner_work_scheduler;

   localparam int N  = 4;
   localparam int CB = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            rx_done = 1'b0;
   logic [N-1:0]    core_load;
   logic [31:0]     core_start_nonce;
   logic [N-1:0]    core_done = '0;
   logic [N-1:0]    core_golden_valid = '0;
   logic [32*N-1:0] core_golden_nonce = '0;
   logic            tx_valid;
   logic            tx_ready = 1'b0;
   logic [31:0]     tx_nonce;
   logic [CB-1:0]   tx_core;
   logic            work_exhausted;
   logic            busy;
   logic [7:0]      drop_count;

   miner_work_scheduler #(.NUM_CORES(N), .CORE_BITS(CB)) dut (
      .clk               (clk),
      .reset             (reset),
      .rx_done           (rx_done),
      .core_load         (core_load),
      .core_start_nonce  (core_start_nonce),
      .core_done         (core_done),
      .core_golden_valid (core_golden_valid),
      .core_golden_nonce (core_golden_nonce),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .tx_nonce          (tx_nonce),
      .tx_core           (tx_core),
      .work_exhausted    (work_exhausted),
      .busy              (busy),
      .drop_count        (drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: mode 0 idle, 1 loading, 2 running, 3 exhausted
   typedef struct {
      int          core;
      logic [31:0] nonce;
   } rep_t;

   rep_t        exp_q[$];
   int          m_mode;
   int          m_k;
   bit [N-1:0]  m_done;
   bit          m_hv [N];
   logic [31:0] m_hn [N];
   int          m_ptr;
   bit          m_txv;
   int          m_drops;

   always @(negedge clk) begin
      bit ld;
      int g;
      int c;
      if (reset) begin
         m_mode  = 0;
         m_k     = 0;
         m_done  = '0;
         m_ptr   = 0;
         m_txv   = 0;
         m_drops = 0;
         for (int i = 0; i < N; i++) begin
            m_hv[i] = 0;
            m_hn[i] = '0;
         end
         exp_q.delete();
      end else begin
         chk("core_load", core_load, (m_mode == 1) ? (1 << m_k) : 0);
         chk("start_nonce", core_start_nonce,
             (m_mode == 1) ? (longint'(m_k) << (32 - CB)) : 64'd0);
         chk("busy", busy, (m_mode == 1) || (m_mode == 2));
         chk("work_exhausted", work_exhausted, m_mode == 3);
         chk("tx_valid", tx_valid, m_txv);
         chk("drop_count", drop_count, m_drops);

         ld = !m_txv || tx_ready;
         if (rx_done) begin
            for (int i = 0; i < N; i++) m_hv[i] = 0;
            if (ld) m_txv = 0;
            m_mode = 1;
            m_k    = 0;
            m_done = '0;
         end else begin
            g = -1;
            if (ld) begin
               for (int j = 0; j < N; j++) begin
                  c = (m_ptr + j) % N;
                  if (g < 0 && m_hv[c]) g = c;
               end
               m_txv = (g >= 0);
               if (g >= 0) begin
                  exp_q.push_back('{g, m_hn[g]});
                  m_hv[g] = 0;
                  m_ptr   = (g + 1) % N;
               end
            end
            if (m_mode != 0) begin
               for (int i = 0; i < N; i++) begin
                  if (core_golden_valid[i]) begin
                     if (m_hv[i]) begin
                        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                     end else begin
                        m_hv[i] = 1;
                        m_hn[i] = core_golden_nonce[32*i +: 32];
                     end
                  end
               end
            end
            case (m_mode)
               1: begin
                  if (m_k == N - 1) m_mode = 2;
                  else m_k++;
               end
               2: begin
                  m_done |= core_done;
                  if (&m_done) m_mode = 3;
               end
               default: ;
            endcase
         end
      end
   end

   // Monitor: each completed handshake must match the next expected report
   always @(negedge clk) begin
      rep_t e;
      if (!reset && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got core %0d nonce 0x%0h, required none",
                     tx_core, tx_nonce);
         end else begin
            e = exp_q.pop_front();
            chk("tx_core", tx_core, e.core);
            chk("tx_nonce", tx_nonce, e.nonce);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gold(int c, logic [31:0] n);
      core_golden_valid[c] = 1'b1;
      core_golden_nonce[32*c +: 32] = n;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_core_load"}, core_load, 0);
      chk({tag, "_start_nonce"}, core_start_nonce, 0);
      chk({tag, "_tx_valid"}, tx_valid, 0);
      chk({tag, "_tx_nonce"}, tx_nonce, 0);
      chk({tag, "_tx_core"}, tx_core, 0);
      chk({tag, "_work_exhausted"}, work_exhausted, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_drop_count"}, drop_count, 0);
   endtask

   initial begin
      repeat (2) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Load sequence
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk("load_onehot", core_load, 1 << k);
         chk("load_nonce", core_start_nonce, longint'(k) * 64'h4000_0000);
         tick();
      end
      chk("run_busy", busy, 1);

      // Completion
      for (int k = 0; k < N; k++) begin
         core_done = N'(1 << k);
         tick();
      end
      core_done = '0;
      chk("exhausted_level", work_exhausted, 1);
      chk("exhausted_busy", busy, 0);
      repeat (2) tick();

      // All cores report at once
      tx_ready = 1'b1;
      gold(0, 32'h11);
      gold(1, 32'h22);
      gold(2, 32'h33);
      gold(3, 32'h44);
      tick();
      core_golden_valid = '0;
      tick();
      chk("burst_first_valid", tx_valid, 1);
      chk("burst_first_core", tx_core, 0);
      repeat (6) tick();

      // Overflow on a single core with a stalled transmitter
      tx_ready = 1'b0;
      gold(2, 32'hA);
      tick();
      gold(2, 32'hB);
      tick();
      gold(2, 32'hC);
      tick();
      core_golden_valid = '0;
      tick();
      chk("single_drop", drop_count, 1);
      chk("stall_nonce", tx_nonce, 32'hA);
      tx_ready = 1'b1;
      repeat (4) tick();

      // New work while a report is presented and another is held
      tx_ready = 1'b0;
      gold(0, 32'h100);
      tick();
      core_golden_valid = '0;
      gold(1, 32'h101);
      tick();
      core_golden_valid = '0;
      tick();
      chk("presented_core", tx_core, 0);
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      chk("presented_kept", tx_valid, 1);
      tx_ready = 1'b1;
      repeat (10) tick();

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         rx_done = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < N; i++) begin
            core_done[i] = ($urandom_range(0, 3) == 0);
            core_golden_valid[i] = ($urandom_range(0, 5) == 0);
            core_golden_nonce[32*i +: 32] = $urandom;
         end
         tx_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      rx_done = 1'b0;
      core_done = '0;
      core_golden_valid = '0;

      // Saturating drop counter
      tx_ready = 1'b0;
      core_golden_valid = '1;
      repeat (100) tick();
      core_golden_valid = '0;
      tick();
      chk("drop_saturated", drop_count, 255);
      tx_ready = 1'b1;
      repeat (20) tick();
      chk("scoreboard_empty", exp_q.size(), 0);

      // Asynchronous reset in the middle of loading
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
      chk("midload_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/miner_work_scheduler.md
# miner_work_scheduler

Sequences hashing work for the blake miner core array. On each new-work strobe from the serial receiver it loads every core with a disjoint slice of the 32-bit nonce space and tracks core completion. It also arbitrates golden-nonce reports from all cores round-robin into a single stream for the serial transmitter. It sits between `serial_receive` and the cores on the input side, and between the cores and the UART transmit path on the output side.

## Interface
- `NUM_CORES`, 4, number of hashing cores; power of two, 1..16
- `CORE_BITS`, 2, log2(`NUM_CORES`), minimum 1; width of core index fields
- `clk` input 1: single clock for all logic
- `reset` input 1: asynchronous, active-high
- `rx_done` input 1: one-cycle new-work strobe from `serial_receive`
- `core_load` output `NUM_CORES`: one-hot, one-cycle load pulse per core
- `core_start_nonce` output 32: first nonce for the core being loaded; valid while `core_load` is nonzero
- `core_done` input `NUM_CORES`: per-core one-cycle pulse when that core's slice is exhausted
- `core_golden_valid` input `NUM_CORES`: per-core one-cycle golden-nonce strobe
- `core_golden_nonce` input 32*`NUM_CORES`: core i occupies bits [32i+31:32i]
- `tx_valid` output 1: golden-nonce report available
- `tx_ready` input 1: transmitter accepts report
- `tx_nonce` output 32: reported nonce
- `tx_core` output `CORE_BITS`: index of the reporting core
- `work_exhausted` output 1: level; all cores finished current work
- `busy` output 1: state is LOAD or RUN
- `drop_count` output 8: saturating count of golden nonces lost to overflow

## Operation
- States:
  - IDLE (reset state)
  - LOAD
  - RUN
  - EXHAUSTED
- Reset values:
  - all outputs 0
  - holding registers empty
  - round-robin pointer 0
  - load index 0
- `rx_done` in any state, including LOAD:
  - next state LOAD, load index 0
  - clear all done bits
  - flush all golden holding registers
  - golden strobes in the same cycle are discarded and not counted as drops
- LOAD lasts exactly `NUM_CORES` cycles, cycle k:
  - `core_load` = 1<<k
  - `core_start_nonce` = k << (32-`CORE_BITS`); with `NUM_CORES`=1 the value is 0
  - after cycle `NUM_CORES`-1, go to RUN
- RUN:
  - `core_done[i]` sets done bit i; repeated pulses are harmless
  - when all done bits are set, go to EXHAUSTED
- `core_done` is ignored in IDLE, LOAD and EXHAUSTED.
- EXHAUSTED: `work_exhausted`=1 until the next `rx_done`.
- Golden capture: accepted in LOAD, RUN and EXHAUSTED; ignored in IDLE.
  - each core has a one-entry holding register
  - capture succeeds if the register is empty, or is being drained to the output in the same cycle
  - otherwise the nonce is dropped and `drop_count` increments, saturating at 255
  - simultaneous drops from several cores add +1 each, clamped at 255
- Arbiter:
  - output register is loadable when `tx_valid`=0, or `tx_valid`&&`tx_ready`
  - if loadable, grant the first full holding register searching upward (with wrap) from the pointer
  - move the granted entry to `tx_nonce`/`tx_core` and clear that holding register
  - set pointer = granted index + 1, modulo `NUM_CORES`
- Output register is never flushed by `rx_done`; a presented report completes its handshake.
- `drop_count` clears only on `reset`.

## Timing
- `rx_done` at cycle t:
  - first `core_load` at t+1
  - last at t+`NUM_CORES`
  - `busy`=1 from t+1
  - RUN entered at t+`NUM_CORES`+1
- Final `core_done` at cycle t: `work_exhausted`=1 and `busy`=0 at t+1.
- Golden strobe at t with empty holding register and idle output: `tx_valid`=1 at t+2. Minimum latency is 2 cycles.
- Handshake:
  - `tx_nonce`/`tx_core` stay stable while `tx_valid`&&!`tx_ready`
  - back-to-back transfers are possible, one per cycle
- `reset` asserted mid-LOAD or mid-handshake: everything returns to reset values immediately; `tx_valid` drops without a handshake.

## Test plan
- `NUM_CORES`=4, pulse `rx_done` -> `core_load` 0001,0010,0100,1000 on the next 4 cycles; start nonces 0x00000000, 0x40000000, 0x80000000, 0xC0000000.
- Pulse `core_done` 0001, 0010, 0100, 1000 in RUN -> `work_exhausted` rises the cycle after the last pulse; a new `rx_done` clears it and restarts LOAD.
- All 4 cores strobe golden nonces 0x11,0x22,0x33,0x44 in one cycle, `tx_ready`=1 -> tx sequence (core0,0x11),(core1,0x22),(core2,0x33),(core3,0x44) on consecutive cycles from t+2.
- `tx_ready`=0, core 2 strobes 0xA then 0xB then 0xC -> 0xA held on tx, 0xB in holding, 0xC dropped, `drop_count`=1; after releasing `tx_ready`, 0xA then 0xB are delivered.
- `rx_done` while core 1 holding is full and tx shows core 0 -> core 0 report completes on `tx_ready`; core 1 entry never appears; LOAD restarts.
- 300 forced overflows -> `drop_count`=255; assert `reset` mid-LOAD -> all outputs 0 and state IDLE.
